wb_rsp_hex_tx: RTL

Downstream stage of the Wishbone command master: accepts 34-bit response words (`o_rsp_stb`/`o_rsp_word` of the master) and serializes each as an ASCII frame toward the UART transmitter (`o_TxStart`/`i_TxBusy`). The master has no response back-pressure, so a small internal FIFO absorbs bursts. Overflow is flagged rather than stalling the bus.

---
 rtl/wb_hex_pkg.sv | 31 +++
 rtl/wb_rsp_fifo.sv | 63 ++++++
 rtl/wb_rsp_hex_tx.sv | 133 +++++++++++++
 3 files changed

// File: rtl/wb_hex_pkg.sv
// Shared types, ASCII constants and helpers for the Wishbone response hex transmitter.
package wb_hex_pkg;

    typedef enum logic [1:0] {
        RSP_WACK  = 2'b00,
        RSP_RDATA = 2'b01,
        RSP_AACK  = 2'b10,
        RSP_ERR   = 2'b11
    } rsp_type_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SEND,
        ST_GAP,
        ST_WAIT
    } tx_state_t;

    localparam logic [7:0] ASCII_K  = 8'h4B;
    localparam logic [7:0] ASCII_R  = 8'h52;
    localparam logic [7:0] ASCII_A  = 8'h41;
    localparam logic [7:0] ASCII_E  = 8'h45;
    localparam logic [7:0] ASCII_CR = 8'h0D;
    localparam logic [7:0] ASCII_LF = 8'h0A;

    // 'A' (0x41) minus 10 is 0x37
    function automatic logic [7:0] hex_ascii(input logic [3:0] i_nib);
        return (i_nib < 4'd10) ? (8'h30 + {4'h0, i_nib}) : (8'h37 + {4'h0, i_nib});
    endfunction

endpackage

// File: rtl/wb_rsp_fifo.sv
// Synchronous FIFO for response words; a push while full is accepted only if a pop
// frees a slot in the same cycle.
module wb_rsp_fifo #(
    parameter int unsigned LGFIFO = 2,
    parameter int unsigned WIDTH  = 34
) (
    input  logic             i_clk,
    input  logic             i_reset_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty
);
    localparam int unsigned DEPTH = 1 << LGFIFO;
    localparam logic [LGFIFO:0] FULL_CNT = (LGFIFO + 1)'(DEPTH);

    logic [WIDTH-1:0]  r_mem [DEPTH];
    logic [LGFIFO-1:0] r_wr_ptr;
    logic [LGFIFO-1:0] r_rd_ptr;
    logic [LGFIFO:0]   r_count;
    logic              r_empty;
    logic [LGFIFO:0]   w_count_nxt;
    logic              w_do_push;
    logic              w_do_pop;

    assign o_full    = (r_count == FULL_CNT);
    assign o_empty   = r_empty;
    assign o_data    = r_mem[r_rd_ptr];
    assign w_do_pop  = i_pop && !r_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);

    always_comb begin
        w_count_nxt = r_count;
        if (w_do_push && !w_do_pop)
            w_count_nxt = r_count + 1'b1;
        else if (!w_do_push && w_do_pop)
            w_count_nxt = r_count - 1'b1;
    end

    always_ff @(posedge i_clk) begin
        if (w_do_push)
            r_mem[r_wr_ptr] <= i_data;
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_empty  <= 1'b1;
        end else begin
            if (w_do_push)
                r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)
                r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count <= w_count_nxt;
            r_empty <= (w_count_nxt == '0);
        end
    end

endmodule

// File: rtl/wb_rsp_hex_tx.sv
// Serializes 34-bit Wishbone responses into ASCII frames for a UART transmitter.
// Define WB_RSP_CRLF_EN to terminate frames with CR LF instead of LF alone.
module wb_rsp_hex_tx
    import wb_hex_pkg::*;
#(
    parameter int unsigned LGFIFO = 2
) (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic        i_rsp_stb,
    input  logic [33:0] i_rsp_word,
    output logic        o_TxStart,
    output logic [7:0]  o_tx_data,
    input  logic        i_TxBusy,
    output logic        o_busy,
    output logic        o_overflow
);
`ifdef WB_RSP_CRLF_EN
    localparam logic [3:0] TERM_BYTES = 4'd2;
`else
    localparam logic [3:0] TERM_BYTES = 4'd1;
`endif

    tx_state_t   r_state;
    tx_state_t   w_state_nxt;
    rsp_type_t   r_type;
    logic [31:0] r_payload;
    logic [3:0]  r_idx;
    logic [7:0]  r_tx_data;
    logic        r_overflow;

    logic [33:0] w_fifo_dout;
    logic        w_full;
    logic        w_empty;
    logic        w_pop;
    logic        w_has_payload;
    logic [3:0]  w_len;
    logic        w_more;
    logic [2:0]  w_digit;
    logic [31:0] w_shifted;
    logic [7:0]  w_byte;

    wb_rsp_fifo #(
        .LGFIFO (LGFIFO),
        .WIDTH  (34)
    ) u_fifo (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .i_push    (i_rsp_stb),
        .i_data    (i_rsp_word),
        .i_pop     (w_pop),
        .o_data    (w_fifo_dout),
        .o_full    (w_full),
        .o_empty   (w_empty)
    );

    assign w_has_payload = (r_type == RSP_RDATA) || (r_type == RSP_AACK);
    assign w_len         = w_has_payload ? (4'd9 + TERM_BYTES) : (4'd1 + TERM_BYTES);
    assign w_more        = (r_idx < w_len);
    assign w_digit       = 3'(r_idx - 4'd1);
    assign w_shifted     = r_payload >> {3'd7 - w_digit, 2'b00};

    // Byte 0 is the prefix, bytes 1..8 the hex digits, the rest the terminator
    always_comb begin
        w_byte = ASCII_LF;
        if (r_idx == 4'd0) begin
            case (r_type)
                RSP_WACK:  w_byte = ASCII_K;
                RSP_RDATA: w_byte = ASCII_R;
                RSP_AACK:  w_byte = ASCII_A;
                default:   w_byte = ASCII_E;
            endcase
        end else if (w_has_payload && (r_idx <= 4'd8)) begin
            w_byte = hex_ascii(w_shifted[3:0]);
`ifdef WB_RSP_CRLF_EN
        end else if (r_idx == (w_len - 4'd2)) begin
            w_byte = ASCII_CR;
`endif
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n)
            r_state <= ST_IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (!w_empty)  w_state_nxt = ST_LOAD;
            ST_LOAD: if (!i_TxBusy) w_state_nxt = ST_SEND;
            ST_SEND: w_state_nxt = ST_GAP;
            ST_GAP:  w_state_nxt = ST_WAIT;
            ST_WAIT: if (!i_TxBusy) w_state_nxt = w_more ? ST_LOAD : ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        o_TxStart = (r_state == ST_SEND);
        w_pop     = (r_state == ST_IDLE) && !w_empty;
        o_busy    = (r_state != ST_IDLE) || !w_empty;
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_type     <= RSP_WACK;
            r_payload  <= '0;
            r_idx      <= '0;
            r_tx_data  <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (i_rsp_stb && w_full && !w_pop)
                r_overflow <= 1'b1;
            case (r_state)
                ST_IDLE: if (w_pop) begin
                    r_type    <= rsp_type_t'(w_fifo_dout[33:32]);
                    r_payload <= w_fifo_dout[31:0];
                    r_idx     <= '0;
                end
                ST_LOAD: r_tx_data <= w_byte;
                ST_SEND: r_idx <= r_idx + 1'b1;
                default: ;
            endcase
        end
    end

    assign o_tx_data  = r_tx_data;
    assign o_overflow = r_overflow;

endmodule
